// File: rtl/ks_decomposer.sv
// rtl/ks_decomposer.sv - streaming balanced signed-digit decomposer for keyswitch
module ks_decomposer #(
    parameter int MOD_Q_W = 64,
    parameter int KS_L    = 5,
    parameter int KS_B_W  = 3,
    parameter int LVL_W   = (KS_L > 1) ? $clog2(KS_L) : 1
) (
    input  logic                clk,
    input  logic                a_rst,
    input  logic [MOD_Q_W-1:0]  in_data,
    input  logic                in_last,
    input  logic                in_vld,
    output logic                in_rdy,
    output logic [KS_B_W:0]     out_digit,
    output logic [LVL_W-1:0]    out_lvl,
    output logic                out_last,
    output logic                out_vld,
    input  logic                out_rdy
);
    localparam int T  = KS_L * KS_B_W;
    localparam int SH = MOD_Q_W - T;
    localparam logic [LVL_W-1:0] LAST_CNT = LVL_W'(KS_L - 1);
    localparam logic [KS_B_W:0]  HALF     = (KS_B_W + 1)'(1 << (KS_B_W - 1));
    localparam logic [KS_B_W:0]  BASE     = (KS_B_W + 1)'(1 << KS_B_W);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [LVL_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [T-1:0]     r_q, r_d;
    logic             last_q, last_d;

    logic [T-1:0]      rounded;
    logic [KS_B_W-1:0] seg;
    logic [KS_B_W:0]   d_sum;
    logic [KS_B_W:0]   digit;
    logic              carry_nxt;
    logic              busy;
    logic              last_step;
    logic              accept_in;
    logic              fire_out;

    // Round to the nearest multiple of 2^SH; overflow wraps modulo 2^T.
    assign rounded = T'((in_data >> SH) + MOD_Q_W'(in_data[SH-1]));

    assign busy      = (state_q == BUSY);
    assign last_step = (cnt_q == LAST_CNT);
    assign in_rdy    = !busy || (last_step && out_rdy);
    assign accept_in = in_vld && in_rdy;
    assign fire_out  = busy && out_rdy;

    // Current level: least-significant chunk first, plus the carry from the level below.
    always_comb begin
        seg   = KS_B_W'(r_q >> (KS_B_W * int'(cnt_q)));
        d_sum = {1'b0, seg} + (KS_B_W + 1)'(carry_q);
        if (d_sum >= HALF) begin
            digit     = d_sum - BASE;
            carry_nxt = 1'b1;
        end else begin
            digit     = d_sum;
            carry_nxt = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        r_d     = r_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (accept_in) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    r_d     = rounded;
                    last_d  = in_last;
                end
            end
            BUSY: begin
                if (fire_out) begin
                    if (last_step) begin
                        cnt_d   = '0;
                        carry_d = 1'b0;
                        if (accept_in) begin
                            r_d    = rounded;
                            last_d = in_last;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d   = cnt_q + LVL_W'(1);
                        carry_d = carry_nxt;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            r_q     <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            r_q     <= r_d;
            last_q  <= last_d;
        end
    end

    // Outputs decode straight from registers, so they freeze under backpressure and clear on reset.
    assign out_vld   = busy;
    assign out_digit = busy ? digit : '0;
    assign out_lvl   = busy ? (LAST_CNT - cnt_q) : '0;
    assign out_last  = busy && last_q && last_step;
endmodule

// File: tb/tb_ks_decomposer.sv
// tb/tb_ks_decomposer.sv - self-checking bench for ks_decomposer
module tb_ks_decomposer;
    localparam int MQ     = 64;
    localparam int KS_L   = 5;
    localparam int KS_B_W = 3;
    localparam int LVL_W  = 3;
    localparam int DW     = KS_B_W + 1;
    localparam int T      = KS_L * KS_B_W;

    logic             clk = 1'b0;
    logic             a_rst;
    logic [MQ-1:0]    in_data;
    logic             in_last;
    logic             in_vld;
    logic             in_rdy;
    logic [DW-1:0]    out_digit;
    logic [LVL_W-1:0] out_lvl;
    logic             out_last;
    logic             out_vld;
    logic             out_rdy;

    ks_decomposer #(.MOD_Q_W(MQ), .KS_L(KS_L), .KS_B_W(KS_B_W), .LVL_W(LVL_W)) dut (
        .clk(clk), .a_rst(a_rst),
        .in_data(in_data), .in_last(in_last), .in_vld(in_vld), .in_rdy(in_rdy),
        .out_digit(out_digit), .out_lvl(out_lvl), .out_last(out_last),
        .out_vld(out_vld), .out_rdy(out_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]    digit;
        logic [LVL_W-1:0] lvl;
        logic             last;
    } ent_t;

    ent_t          q[$];
    logic [MQ-1:0] rq[$];
    logic [MQ-1:0] sum;
    int            nvec = 0;
    int            nerr = 0;
    logic          stalled = 1'b0;
    logic [DW-1:0]    prev_digit;
    logic [LVL_W-1:0] prev_lvl;
    logic             prev_last;

    task automatic chk(input string tag, input logic [MQ-1:0] got, input logic [MQ-1:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: balanced base-2^B digits of the rounded value via signed remainders.
    task automatic push_model(input logic [MQ-1:0] x, input logic lst);
        longint unsigned rr;
        longint          v;
        longint          m;
        ent_t            e;
        rr = ((x >> (MQ - T)) + ((x >> (MQ - T - 1)) & 64'd1)) % (64'd1 << T);
        rq.push_back(rr);
        v = longint'(rr);
        for (int k = 0; k < KS_L; k++) begin
            m = v % (1 << KS_B_W);
            if (m >= (1 << (KS_B_W - 1))) m = m - (1 << KS_B_W);
            v = (v - m) / (1 << KS_B_W);
            e.digit = DW'(m);
            e.lvl   = LVL_W'(KS_L - 1 - k);
            e.last  = (k == KS_L - 1) && lst;
            q.push_back(e);
        end
    endtask

    task automatic cycle(input logic vld, input logic [MQ-1:0] data, input logic lst,
                         input logic ordy, output logic acc);
        ent_t e;
        logic exp_vld;
        logic exp_rdy;
        in_vld  = vld;
        in_data = data;
        in_last = lst;
        out_rdy = ordy;
        #1;
        exp_vld = (q.size() != 0);
        exp_rdy = (q.size() == 0) || (q.size() == 1 && ordy);
        chk("out_vld", out_vld, exp_vld);
        chk("in_rdy", in_rdy, exp_rdy);
        if (exp_vld) begin
            e = q[0];
            chk("digit", out_digit, e.digit);
            chk("lvl", out_lvl, e.lvl);
            chk("last", out_last, e.last);
        end else begin
            chk("idle_digit", out_digit, 0);
            chk("idle_lvl", out_lvl, 0);
            chk("idle_last", out_last, 0);
        end
        if (stalled) begin
            chk("stall_digit", out_digit, prev_digit);
            chk("stall_lvl", out_lvl, prev_lvl);
            chk("stall_last", out_last, prev_last);
        end
        prev_digit = out_digit;
        prev_lvl   = out_lvl;
        prev_last  = out_last;
        stalled    = exp_vld && !ordy;
        acc        = vld && exp_rdy;
        if (exp_vld && ordy) begin
            sum = sum + ({{(MQ-DW){out_digit[DW-1]}}, out_digit} << (MQ - (int'(e.lvl) + 1) * KS_B_W));
            if (e.lvl == 0) begin
                chk("recon_sum", sum, rq.pop_front() << (MQ - T));
                sum = '0;
            end
            void'(q.pop_front());
        end
        if (acc) push_model(data, lst);
        @(negedge clk);
    endtask

    task automatic feed(input logic [MQ-1:0] data, input logic lst);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            cycle(1'b1, data, lst, 1'b1, acc);
            n++;
        end
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            cycle(1'b0, '0, 1'b0, 1'b1, acc);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        logic [MQ-1:0] vec [5];
        logic [MQ-1:0] cur;
        logic          cur_last;
        logic          acc;
        int            accepted;

        sum = '0;
        a_rst = 1'b1; in_vld = 1'b0; in_data = '0; in_last = 1'b0; out_rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_digit", out_digit, 0);
        chk("rst_lvl", out_lvl, 0);
        chk("rst_last", out_last, 0);
        chk("rst_in_rdy", in_rdy, 1);
        a_rst = 1'b0;
        cycle(1'b0, '0, 1'b0, 1'b1, acc);

        vec[0] = 64'h0;
        vec[1] = 64'h8000_0000_0000_0000;
        vec[2] = 64'h0001_0000_0000_0000;
        vec[3] = 64'h0008_0000_0000_0000;
        vec[4] = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 5; i++) feed(vec[i], i[0]);
        drain();

        // Reset while the level-2 digit is on the output.
        feed(64'h0008_0000_0000_0000, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1, acc);
        cycle(1'b0, '0, 1'b0, 1'b1, acc);
        chk("pre_rst_lvl", out_lvl, 2);
        a_rst = 1'b1;
        #1;
        chk("arst_out_vld", out_vld, 0);
        chk("arst_digit", out_digit, 0);
        chk("arst_lvl", out_lvl, 0);
        chk("arst_last", out_last, 0);
        chk("arst_in_rdy", in_rdy, 1);
        q.delete();
        rq.delete();
        sum = '0;
        stalled = 1'b0;
        @(negedge clk);
        a_rst = 1'b0;
        cycle(1'b0, '0, 1'b0, 1'b1, acc);
        cycle(1'b0, '0, 1'b0, 1'b1, acc);
        feed(64'h0001_0000_0000_0000, 1'b1);
        drain();

        // Random data and handshakes; data held until accepted.
        cur = {$urandom, $urandom};
        cur_last = 1'(($urandom));
        accepted = 0;
        for (int c = 0; c < 4000 && accepted < 250; c++) begin
            cycle(1'($urandom_range(0, 3) != 0), cur, cur_last, 1'($urandom_range(0, 3) != 0), acc);
            if (acc) begin
                accepted++;
                cur = {$urandom, $urandom};
                if ($urandom_range(0, 7) == 0) cur = cur | 64'hFFFF_0000_0000_0000;
                cur_last = 1'(($urandom));
            end
        end
        if (accepted < 250) chk("random_accept_budget", 0, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/ks_decomposer.md
# ks_decomposer

Streaming signed-digit decomposer for the keyswitch stage. Takes 64-bit LWE coefficients from the blind-rotation/sample-extract output, rounds each to the closest value representable with KS_L levels of KS_B_W bits, and emits KS_L balanced signed digits per coefficient, least-significant level first. The keyswitch multiply-accumulate stage downstream consumes the digits. The active parameter set (MSG2_CARRY2_GAUSSIAN: MOD_Q_W=64, KS_L=5, KS_B_W=3) supplies the defaults.

## Interface
- MOD_Q_W, 64: coefficient width in bits.
- KS_L, 5: number of decomposition levels, at least 1.
- KS_B_W, 3: bits per level, at least 2; requires KS_L*KS_B_W < MOD_Q_W.
- LVL_W, $clog2(KS_L) with a minimum of 1: level index width.
- clk  in  1  clock.
- a_rst  in  1  reset. One clock domain; reset is asynchronous and active-high.
- in_data  in  MOD_Q_W  coefficient to decompose.
- in_last  in  1  marks the last coefficient of a ciphertext (body).
- in_vld  in  1  input valid.
- in_rdy  out  1  input ready.
- out_digit  out  KS_B_W+1  signed two's-complement digit.
- out_lvl  out  LVL_W  level of the current digit; 0 is the most significant level.
- out_last  out  1  in_last of the source coefficient, asserted only on its level-0 digit.
- out_vld  out  1  output valid.
- out_rdy  in  1  output ready.

## Operation
- Define T = KS_L*KS_B_W and H = 2^(KS_B_W-1).
- **Rounding on accept.** r = (in_data >> (MOD_Q_W-T)) + in_data[MOD_Q_W-T-1], truncated to T bits. Overflow wraps modulo 2^T, which is the same as wrapping modulo 2^MOD_Q_W.
- **Registering.** Store r, in_last and carry=0 into a working register when the input is accepted.
- **Digit generation**, step k = 0..KS_L-1, emitting level KS_L-1-k:
  - d = r[k*KS_B_W +: KS_B_W] + carry. This is unsigned and may equal 2^KS_B_W.
  - If d >= H: digit = d - 2^KS_B_W and carry = 1.
  - Otherwise: digit = d and carry = 0.
  - Digit range is [-H, H-1].
  - The carry out of level 0 is discarded.
- **State machine.** Two states, IDLE and BUSY, with step counter cnt of LVL_W bits.
  - IDLE to BUSY on in_vld & in_rdy; cnt=0.
  - In BUSY, each out_vld & out_rdy advances cnt and carry.
  - When cnt=KS_L-1 and the output is accepted: go to BUSY with cnt=0 if a new input is accepted in the same cycle, otherwise go to IDLE.
- **Combinational ready.** in_rdy = IDLE | (BUSY & cnt==KS_L-1 & out_rdy).
- **Output.** out_vld = BUSY. out_digit, out_lvl and out_last are valid whenever out_vld=1 and are held stable while out_vld & !out_rdy.
- **Idle values.** When out_vld=0, out_digit, out_lvl and out_last are driven to 0.

## Timing
- **Reset values.** out_vld=0, out_digit=0, out_lvl=0, out_last=0, state=IDLE, cnt=0, carry=0. in_rdy reads 1 after reset.
- **Reset mid-coefficient.** The partially emitted coefficient is dropped. No digit appears after reset deassertion until a new input is accepted.
- **Latency.** Input accepted at edge t gives the first digit (level KS_L-1) with out_vld=1 in the cycle after t.
- **Throughput.** With out_rdy held at 1 there is one digit per cycle and one coefficient every KS_L cycles, with no bubble between coefficients.
- **Backpressure.** out_rdy=0 freezes cnt, carry and every output. in_rdy stays 0 throughout BUSY unless the last digit is being accepted.
- **Input while busy.** The block never drops or overwrites an input. in_vld while in_rdy=0 is ignored, and the source must hold it.
- **KS_L=1.** There is only one step, cnt stays 0, and the block behaves as a single-entry pipe.

## Test plan
Defaults are used throughout (T=15, H=4). Digits are listed in emission order lvl4..lvl0.
- in_data=0 -> digits 0,0,0,0,0; out_last follows in_last on the lvl0 digit only.
- in_data=2^63 (r=0x4000) -> 0,0,0,0,-4 (level-0 carry discarded); in_data=2^48 (rounding bit only, r=1) -> 1,0,0,0,0.
- in_data=2^51 (r=4) -> -4,1,0,0,0; in_data=2^64-1 (r wraps to 0) -> 0,0,0,0,0.
- Back-to-back inputs with out_rdy=1 -> 10 digits in 10 consecutive cycles; in_rdy=1 exactly on each lvl0 cycle.
- Random out_rdy deassertion -> outputs stable while stalled; a scoreboard confirms sum(digit_l * 2^(MOD_Q_W-(l+1)*KS_B_W)) mod 2^64 equals the rounded input.
- Assert a_rst during the lvl2 digit -> all outputs go to 0 immediately; the next accepted input restarts at lvl4 with correct digits.
